// File: rtl/rotate_cmd_queue.sv
// rotate_cmd_queue -- buffered command front-end for an external N-bit barrel
// rotator. Commands {data, amount, direction} are queued in a DEPTH-entry
// FIFO. The FIFO head drives the rotator combinationally, and the rotator
// result is captured into a registered output stage. The rotator therefore
// sits between two registered boundaries.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   flush             synchronous clear of the FIFO and the output valid
//   in_valid/ready    command handshake; in_data, in_amt, in_dir
//   rot_data_in/amt/dir  FIFO head, driven to the rotator
//   rot_data_out      rotator result
//   out_valid/ready   result handshake; out_data, out_dir
//   count             FIFO occupancy (the output stage is not included)
module rotate_cmd_queue #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  input  logic [$clog2(N)-1:0]       in_amt,
  input  logic                       in_dir,
  output logic [N-1:0]               rot_data_in,
  output logic [$clog2(N)-1:0]       rot_amt,
  output logic                       rot_dir,
  input  logic [N-1:0]               rot_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic                       out_dir,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]  r_data [DEPTH];
  logic [AW-1:0] r_amt  [DEPTH];
  logic          r_dir  [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic          r_out_dir;

  logic w_push, w_load, w_in_ready;

  // Ready depends only on registered occupancy: a pop in the same cycle does
  // not open a slot for a push until the next cycle.
  assign w_in_ready = (r_count < DEPTH_C);
  assign w_push     = in_valid && w_in_ready;
  assign w_load     = (r_count != '0) && (!r_out_valid || out_ready);

  assign rot_data_in = r_data[r_rptr];
  assign rot_amt     = r_amt[r_rptr];
  assign rot_dir     = r_dir[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_amt[i]  <= '0;
        r_dir[i]  <= 1'b0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_dir   <= 1'b0;
    end else if (flush) begin
      // Storage and the last result are left intact; only the bookkeeping
      // and the valid flag are cleared.
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= in_data;
        r_amt[r_wptr]  <= in_amt;
        r_dir[r_wptr]  <= in_dir;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_load) begin
        r_out_data  <= rot_data_out;
        r_out_dir   <= rot_dir;
        r_out_valid <= 1'b1;
        r_rptr      <= r_rptr + PW'(1);
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_dir   = r_out_dir;
  assign count     = r_count;

endmodule
